// File: rtl/cspwm_pkg.sv
// cspwm_pkg: shared definitions for the carrier-phase-shifted PWM calculator.
//   DW           data word width (16)
//   Q15_MAX/MIN  saturation bounds of a signed Q15 word
//   Q15_SHIFT    renormalisation shift after a Q15 multiply
//   seq_state_e  compare-level sequencer states
//   sat16()      saturate a 32-bit signed value to a signed 16-bit word
package cspwm_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned Q15_SHIFT = 15;

  localparam logic signed [DW-1:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] Q15_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    StIdle,
    StSeq,
    StDrain,
    StReady
  } seq_state_e;

  function automatic logic signed [DW-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return Q15_MAX;
    end else if (x < -32'sd32768) begin
      return Q15_MIN;
    end
    return x[DW-1:0];
  endfunction

endpackage

// File: rtl/cspwm_calc_mp_if.sv
// cspwm_calc_mp_if: operand/result bundle of the PWM calculator.
//   slave  modport: calculator side (reads i_*, drives o_*)
//   master modport: controller side (drives i_*, reads o_*)
//   Flat vectors pack phase p / module k at bit offset p*16 / k*16; o_pwm packs {B,A} at k*2.
interface cspwm_calc_mp_if
  import cspwm_pkg::*;
#(
  parameter int unsigned N_PH  = 3,
  parameter int unsigned N_MOD = 24
);
  localparam int unsigned N = N_PH * N_MOD;

  logic                 i_start_pwm;
  logic                 i_mode_indep;
  logic                 i_carrier_syn;
  logic [DW-1:0]        i_freq_cnt;
  logic [N_PH*DW-1:0]   i_target_vol;
  logic [N_PH*DW-1:0]   i_cos_thet;
  logic [N_PH*DW-1:0]   i_phase_udc;
  logic [N*DW-1:0]      i_link_udc;
  logic [N*DW-1:0]      i_init_angle;
  logic [DW-1:0]        i_kp_udc;
  logic [DW-1:0]        i_udc_limit;
  logic [N*2-1:0]       o_pwm;
  logic [N*DW-1:0]      o_ctrl_vol;
  logic                 o_calc_busy;
  logic                 o_calc_done;
  logic                 o_overrun;

  modport slave (
    input  i_start_pwm, i_mode_indep, i_carrier_syn, i_freq_cnt, i_target_vol, i_cos_thet,
           i_phase_udc, i_link_udc, i_init_angle, i_kp_udc, i_udc_limit,
    output o_pwm, o_ctrl_vol, o_calc_busy, o_calc_done, o_overrun
  );

  modport master (
    output i_start_pwm, i_mode_indep, i_carrier_syn, i_freq_cnt, i_target_vol, i_cos_thet,
           i_phase_udc, i_link_udc, i_init_angle, i_kp_udc, i_udc_limit,
    input  o_pwm, o_ctrl_vol, o_calc_busy, o_calc_done, o_overrun
  );

endinterface

// File: rtl/cspwm_carrier_cmp.sv
// cspwm_carrier_cmp: one module's phase-shifted triangular carrier and leg comparators.
//   i_clk, i_reset   clock, async active-high reset
//   i_en             run enable; legs are forced low while clear
//   i_cnt, i_period  master counter and carrier period P
//   i_angle          carrier offset in ticks (values >= P act as P-1)
//   i_load, i_clear  copy i_cmp into the active compare level / zero it
//   i_cmp            shadow compare level
//   o_pwm            registered legs {B,A}
module cspwm_carrier_cmp
  import cspwm_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [DW-1:0] i_cnt,
  input  logic [DW-1:0] i_period,
  input  logic [DW-1:0] i_angle,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [DW-1:0] i_cmp,
  output logic [1:0]    o_pwm
);

  logic [DW-1:0] w_ang;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_c;
  logic [DW+1:0] w_tri;
  logic [DW:0]   w_cmp_b;
  logic [DW-1:0] r_active;
  logic          r_leg_a;
  logic          r_leg_b;

  assign w_ang   = (i_angle >= i_period) ? i_period - 16'd1 : i_angle;
  assign w_sum   = {1'b0, i_cnt} + {1'b0, w_ang};
  assign w_c     = (w_sum >= {1'b0, i_period}) ? w_sum - {1'b0, i_period} : w_sum;
  // Rising slope in the first half period, falling slope in the second; peak is P.
  assign w_tri   = (w_c < {2'b0, i_period[DW-1:1]}) ? {w_c, 1'b0}
                                                     : {({1'b0, i_period} - w_c), 1'b0};
  assign w_cmp_b = {1'b0, i_period} - {1'b0, r_active};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_active <= '0;
      r_leg_a  <= 1'b0;
      r_leg_b  <= 1'b0;
    end else begin
      if (i_clear) begin
        r_active <= '0;
      end else if (i_load) begin
        r_active <= i_cmp;
      end
      r_leg_a <= i_en && (w_tri < {2'b0, r_active});
      r_leg_b <= i_en && (w_tri < {1'b0, w_cmp_b});
    end
  end

  assign o_pwm = {r_leg_b, r_leg_a};

endmodule

// File: rtl/cspwm_calc_mp.sv
// cspwm_calc_mp: time-multiplexed CPS-PWM calculator for N_PH x N_MOD H-bridge modules.
//   i_clk, i_reset  clock, async active-high reset
//   bus (slave)     operands in, PWM legs / control voltages / status out
// A sequencer walks all modules once per carrier period through a 4-stage pipeline, filling a
// shadow compare bank that is copied to the carrier comparators atomically at the next period
// start. Define CSPWM_BALANCE_EN to include the capacitor-balancing correction; without it the
// correction is zero and the pipeline depth is unchanged.
module cspwm_calc_mp
  import cspwm_pkg::*;
#(
  parameter int unsigned N_PH   = 3,
  parameter int unsigned N_MOD  = 24,
  parameter int unsigned PW_MIN = 320
) (
  input logic              i_clk,
  input logic              i_reset,
  cspwm_calc_mp_if.slave   bus
);

  localparam int unsigned N  = N_PH * N_MOD;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = (N_PH > 1) ? $clog2(N_PH) : 1;
  localparam int unsigned MW = (N_MOD > 1) ? $clog2(N_MOD) : 1;

  logic [DW-1:0] w_period;
  logic          w_start;
  assign w_period = bus.i_freq_cnt;
  assign w_start  = bus.i_start_pwm;

  // ---------------- master counter and period start ----------------
  logic [DW-1:0] r_cnt;
  logic          r_syn_prev, r_syn_rise, r_pst_q;
  logic          w_pstart, w_idle, w_load, w_issue;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_syn_prev <= 1'b0;
      r_syn_rise <= 1'b0;
      r_pst_q    <= 1'b0;
    end else begin
      r_syn_prev <= bus.i_carrier_syn;
      r_syn_rise <= bus.i_carrier_syn & ~r_syn_prev;
      r_pst_q    <= w_pstart;
      if (!w_start || r_syn_rise || ({1'b0, r_cnt} + 17'd1 >= {1'b0, w_period})) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // A sync landing on a counter already at 0 must not create a second period start.
  assign w_pstart = w_start && (r_cnt == '0) && !r_pst_q;

  // ---------------- sequencer ----------------
  seq_state_e    r_state;
  logic [KW-1:0] r_k;
  logic [PW-1:0] r_p;
  logic [MW-1:0] r_m;
  logic [1:0]    r_drain;
  logic          r_ready, r_done, r_overrun;

  assign w_idle  = (r_state == StIdle);
  assign w_load  = w_pstart && w_idle && r_ready;
  assign w_issue = w_start && (r_state == StSeq);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_k       <= '0;
      r_p       <= '0;
      r_m       <= '0;
      r_drain   <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pstart && !w_idle) begin
        r_overrun <= 1'b1;
      end
      if (!w_start) begin
        r_state <= StIdle;
        r_ready <= 1'b0;
        r_k     <= '0;
        r_p     <= '0;
        r_m     <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_pstart) begin
              r_state <= StSeq;
              r_k     <= '0;
              r_p     <= '0;
              r_m     <= '0;
              r_ready <= 1'b0;  // consumed by w_load in this same cycle, if it was set
            end
          end
          StSeq: begin
            if (r_k == KW'(N - 1)) begin
              r_state <= StDrain;
              r_drain <= '0;
            end else begin
              r_k <= r_k + 1'b1;
              if (r_m == MW'(N_MOD - 1)) begin
                r_m <= '0;
                r_p <= r_p + 1'b1;
              end else begin
                r_m <= r_m + 1'b1;
              end
            end
          end
          StDrain: begin
            if (r_drain == 2'd2) begin
              r_state <= StReady;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_drain <= r_drain + 2'd1;
            end
          end
          StReady: r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // ---------------- compare-level pipeline ----------------
  logic [PW-1:0]        w_q;
  logic signed [DW-1:0] w_tgt;
  assign w_q   = bus.i_mode_indep ? r_p : '0;
  assign w_tgt = bus.i_target_vol[w_q*DW +: DW];

  logic                 r_s0_vld, r_s1_vld, r_s2_vld;
  logic [KW-1:0]        r_s0_k, r_s1_k, r_s2_k;
  logic signed [DW-1:0] r_s0_tgt, r_s1_tgt, r_s2_tgt;
  logic signed [31:0]   w_corr32;

`ifdef CSPWM_BALANCE_EN
  logic signed [DW-1:0] w_ph, w_lk, w_cos, w_kp;
  logic signed [DW:0]   w_dev_raw, w_lim, w_dev;
  logic signed [31:0]   w_prod1;
  logic signed [32:0]   w_prod2;
  logic signed [DW:0]   r_s0_dev, r_s1_dev;
  logic signed [DW-1:0] r_s0_cos, r_s1_ck;
  logic signed [DW+1:0] r_s2_corr;

  assign w_ph      = bus.i_phase_udc[w_q*DW +: DW];
  assign w_lk      = bus.i_link_udc[r_k*DW +: DW];
  assign w_cos     = bus.i_cos_thet[w_q*DW +: DW];
  assign w_kp      = bus.i_kp_udc;
  assign w_dev_raw = {w_ph[DW-1], w_ph} - {w_lk[DW-1], w_lk};
  assign w_lim     = {1'b0, bus.i_udc_limit};
  assign w_dev     = (w_dev_raw > w_lim) ? w_lim : ((w_dev_raw < -w_lim) ? -w_lim : w_dev_raw);
  assign w_prod1   = r_s0_cos * w_kp;
  assign w_prod2   = r_s1_ck * r_s1_dev;
  assign w_corr32  = 32'(r_s2_corr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s0_dev  <= '0;
      r_s0_cos  <= '0;
      r_s1_dev  <= '0;
      r_s1_ck   <= '0;
      r_s2_corr <= '0;
    end else begin
      r_s0_dev  <= w_dev;
      r_s0_cos  <= w_cos;
      r_s1_dev  <= r_s0_dev;
      r_s1_ck   <= sat16(w_prod1 >>> Q15_SHIFT);
      r_s2_corr <= 18'(w_prod2 >>> Q15_SHIFT);
    end
  end
`else
  assign w_corr32 = '0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s0_vld <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s0_k   <= '0;
      r_s1_k   <= '0;
      r_s2_k   <= '0;
      r_s0_tgt <= '0;
      r_s1_tgt <= '0;
      r_s2_tgt <= '0;
    end else begin
      // Dropping start flushes in-flight work so o_ctrl_vol keeps its last values.
      r_s0_vld <= w_issue;
      r_s1_vld <= r_s0_vld && w_start;
      r_s2_vld <= r_s1_vld && w_start;
      r_s0_k   <= r_k;
      r_s1_k   <= r_s0_k;
      r_s2_k   <= r_s1_k;
      r_s0_tgt <= w_tgt;
      r_s1_tgt <= r_s0_tgt;
      r_s2_tgt <= r_s1_tgt;
    end
  end

  // S3: final voltage, compare level with minimum-pulse clamping.
  logic signed [31:0]   w_sum;
  logic signed [DW-1:0] w_vol;
  logic [DW-1:0]        w_off, w_cmp_raw, w_cmp;
  logic [31:0]          w_cmp_prod;

  assign w_sum      = 32'(r_s2_tgt) + w_corr32;
  assign w_vol      = sat16(w_sum);
  assign w_off      = {~w_vol[DW-1], w_vol[DW-2:0]};  // vol + 32768 as unsigned
  assign w_cmp_prod = {16'b0, w_off} * {16'b0, w_period};
  assign w_cmp_raw  = 16'(w_cmp_prod >> 16);

  always_comb begin
    w_cmp = w_cmp_raw;
    if (32'(w_cmp_raw) < PW_MIN) begin
      w_cmp = '0;
    end else if (32'(w_cmp_raw) + PW_MIN > 32'(w_period)) begin
      w_cmp = w_period;
    end
  end

  logic [DW-1:0] r_vol    [N];
  logic [DW-1:0] r_shadow [N];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(N); i++) begin
        r_vol[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else if (r_s2_vld) begin
      r_vol[r_s2_k]    <= w_vol;
      r_shadow[r_s2_k] <= w_cmp;
    end
  end

  // ---------------- carrier bank ----------------
  for (genvar g = 0; g < int'(N); g++) begin : g_mod
    cspwm_carrier_cmp u_carrier (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (w_start),
      .i_cnt    (r_cnt),
      .i_period (w_period),
      .i_angle  (bus.i_init_angle[g*DW +: DW]),
      .i_load   (w_load),
      .i_clear  (!w_start),
      .i_cmp    (r_shadow[g]),
      .o_pwm    (bus.o_pwm[2*g +: 2])
    );
    assign bus.o_ctrl_vol[g*DW +: DW] = r_vol[g];
  end

  assign bus.o_calc_busy = !w_idle;
  assign bus.o_calc_done = r_done;
  assign bus.o_overrun   = r_overrun;

endmodule
